// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised single-clock FIFO family.
package fifo_pkg;

    localparam int unsigned FIFO_DATA_WIDTH = 8;
    localparam int unsigned FIFO_ADDR_WIDTH = 9;

    // Read-mode selectors for the FWFT parameter.
    localparam int unsigned FIFO_STD  = 0;
    localparam int unsigned FIFO_FWFT = 1;

    // Occupancy needs one extra bit so that DEPTH itself is representable.
    function automatic int unsigned count_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/sync_dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, same clock.
// Read-during-write to the same address returns the old word.
module sync_dp_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  w_en,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  r_en,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    output logic [DATA_WIDTH-1:0] r_data
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage is never reset; only the read register has a defined reset value.
    always_ff @(posedge clk) begin
        if (w_en) begin
            mem[w_addr] <= w_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
        end else if (r_en) begin
            r_data <= mem[r_addr];
        end
    end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost flags, sticky
// error flags and an optional first-word-fall-through read mode.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = FIFO_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH    = FIFO_ADDR_WIDTH,
    parameter int unsigned AFULL_THRESH  = (1 << ADDR_WIDTH) - 4,
    parameter int unsigned AEMPTY_THRESH = 4,
    parameter int unsigned FWFT          = FIFO_STD
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                w_enable,
    input  logic [DATA_WIDTH-1:0]               w_data,
    input  logic                                r_enable,
    output logic [DATA_WIDTH-1:0]               r_data,
    output logic                                r_valid,
    output logic                                full,
    output logic                                empty,
    output logic                                almost_full,
    output logic                                almost_empty,
    output logic [count_width(ADDR_WIDTH)-1:0]  fcounter,
    output logic                                overflow,
    output logic                                underflow,
    input  logic                                clr_err
);

    localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
    localparam int unsigned CW      = count_width(ADDR_WIDTH);
    localparam bit          IS_FWFT = (FWFT == FIFO_FWFT);

    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("sync_fifo_param: AFULL_THRESH must lie in 1..DEPTH");
    end
    if (AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
        $error("sync_fifo_param: AEMPTY_THRESH must lie in 0..DEPTH-1");
    end
    if (FWFT > FIFO_FWFT) begin : g_bad_mode
        $error("sync_fifo_param: FWFT must be 0 or 1");
    end

    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_next;
    logic [CW-1:0]         unfetched;
    logic                  out_valid;
    logic                  out_valid_next;
    logic                  w_allow;
    logic                  r_allow;
    logic                  fetch;
    logic                  ram_re;
    logic                  overflow_next;
    logic                  underflow_next;

    // Status flags decode the registered count only; FWFT empty follows the head register.
    always_comb begin
        full         = (count == CW'(DEPTH));
        almost_full  = (count >= CW'(AFULL_THRESH));
        almost_empty = (count <= CW'(AEMPTY_THRESH));
        empty        = IS_FWFT ? ~out_valid : (count == '0);
    end

    // Accept decisions, RAM read scheduling and output-valid next state.
    // In FWFT mode out_valid marks a word sitting in the RAM read register;
    // the next word is fetched whenever one is stored and the head is free or leaving.
    always_comb begin
        w_allow        = w_enable & ~full;
        r_allow        = r_enable & ~empty;
        unfetched      = count - CW'(out_valid);
        fetch          = (unfetched != '0) & (~out_valid | r_allow);
        ram_re         = r_allow;
        out_valid_next = r_allow;
        if (IS_FWFT) begin
            ram_re         = fetch;
            out_valid_next = fetch | (out_valid & ~r_allow);
        end
    end

    // Occupancy and sticky error flags; a new error beats a same-cycle clear.
    always_comb begin
        count_next = count;
        case ({w_allow, r_allow})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
        overflow_next  = (overflow  & ~clr_err) | (w_enable & full);
        underflow_next = (underflow & ~clr_err) | (r_enable & empty);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_addr    <= '0;
            r_addr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_allow) begin
                w_addr <= w_addr + ADDR_WIDTH'(1);
            end
            if (ram_re) begin
                r_addr <= r_addr + ADDR_WIDTH'(1);
            end
            count     <= count_next;
            out_valid <= out_valid_next;
            overflow  <= overflow_next;
            underflow <= underflow_next;
        end
    end

    assign fcounter = count;
    assign r_valid  = out_valid;

    sync_dp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .reset  (reset),
        .w_en   (w_allow),
        .w_addr (w_addr),
        .w_data (w_data),
        .r_en   (ram_re),
        .r_addr (r_addr),
        .r_data (r_data)
    );

endmodule
